ex_muldiv: RTL and testbench

- Multi-cycle multiply/divide unit beside the single-cycle EX ALU.
- Executes MULT/MULTU/DIV/DIVU and the accumulate forms MADD/MADDU/MSUB/MSUBU, producing a HI/LO write.
- Holds the pipeline through stall_o until the result is ready. flush_i cancels the operation on exception.

---
 rtl/ex_muldiv_if.sv | 27 ++
 rtl/ex_muldiv.sv | 164 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Handshake between the EX stage and the multi-cycle multiply/divide unit.
// master = pipeline side, slave = ex_muldiv.
interface ex_muldiv_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic [2:0]       op_i;
  logic             unsigned_i;
  logic [WIDTH-1:0] opa_i;
  logic [WIDTH-1:0] opb_i;
  logic [WIDTH-1:0] acc_hi_i;
  logic [WIDTH-1:0] acc_lo_i;
  logic             flush_i;
  logic             stall_o;
  logic             done_o;
  logic             whilo_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, unsigned_i, opa_i, opb_i, acc_hi_i, acc_lo_i, flush_i,
    input  stall_o, done_o, whilo_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, unsigned_i, opa_i, opb_i, acc_hi_i, acc_lo_i, flush_i,
    output stall_o, done_o, whilo_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/DIV/MADD/MSUB unit producing a HI/LO write; stalls EX until done.
//   state | meaning
//   IDLE  | waiting for a non-NOP start
//   MUL   | multiply/accumulate latency countdown
//   DIV   | restoring radix-2 divide, one quotient bit per cycle
//   SIGN  | apply quotient/remainder signs
//   DONE  | one-cycle result pulse, HI/LO write
module ex_muldiv #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2
) (
  input logic       clk,
  input logic       rst,
  ex_muldiv_if.slave bus
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, SIGN, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 8);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_r;
  logic             uns_r;
  logic [WIDTH-1:0] a_r, b_r, acch_r, accl_r;
  logic [WIDTH-1:0] quo, rem, dvs;
  logic             q_neg, r_neg;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             done_r;

  logic             accept, is_div, div_signed;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [2:0]         m_op;
  logic               m_uns, m_signed;
  logic [WIDTH-1:0]   m_a, m_b, m_ah, m_al;
  logic [2*WIDTH-1:0] ea, eb, prod, mul_res;

  logic [WIDTH:0]   shifted, diff;
  logic             fits;

  always_comb begin
    accept     = (state == IDLE) && bus.start_i && (bus.op_i != 3'd0) && !bus.flush_i;
    is_div     = (bus.op_i == 3'd3) || (bus.op_i == 3'd4);
    div_signed = (bus.op_i == 3'd3);
    a_mag      = (div_signed && bus.opa_i[WIDTH-1]) ? -bus.opa_i : bus.opa_i;
    b_mag      = (div_signed && bus.opb_i[WIDTH-1]) ? -bus.opb_i : bus.opb_i;
  end

  // Multiplier reads the live inputs only when MUL_LATENCY=1 finishes straight from IDLE.
  always_comb begin
    m_op  = (state == IDLE) ? bus.op_i       : op_r;
    m_uns = (state == IDLE) ? bus.unsigned_i : uns_r;
    m_a   = (state == IDLE) ? bus.opa_i      : a_r;
    m_b   = (state == IDLE) ? bus.opb_i      : b_r;
    m_ah  = (state == IDLE) ? bus.acc_hi_i   : acch_r;
    m_al  = (state == IDLE) ? bus.acc_lo_i   : accl_r;
    m_signed = (m_op == 3'd1) || (m_op == 3'd5) || ((m_op == 3'd7) && !m_uns);
    ea   = m_signed ? {{WIDTH{m_a[WIDTH-1]}}, m_a} : {{WIDTH{1'b0}}, m_a};
    eb   = m_signed ? {{WIDTH{m_b[WIDTH-1]}}, m_b} : {{WIDTH{1'b0}}, m_b};
    prod = ea * eb;
    case (m_op)
      3'd5, 3'd6: mul_res = {m_ah, m_al} + prod;
      3'd7:       mul_res = {m_ah, m_al} - prod;
      default:    mul_res = prod;
    endcase
  end

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    fits    = shifted >= {1'b0, dvs};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_r   <= '0;
      uns_r  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      acch_r <= '0;
      accl_r <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.flush_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (accept) begin
            op_r   <= bus.op_i;
            uns_r  <= bus.unsigned_i;
            a_r    <= bus.opa_i;
            b_r    <= bus.opb_i;
            acch_r <= bus.acc_hi_i;
            accl_r <= bus.acc_lo_i;
            if (is_div) begin
              if (bus.opb_i == '0) begin
                hi_r   <= bus.opa_i;
                lo_r   <= '1;
                done_r <= 1'b1;
                state  <= DONE;
              end else begin
                rem   <= '0;
                quo   <= a_mag;
                dvs   <= b_mag;
                q_neg <= div_signed && (bus.opa_i[WIDTH-1] ^ bus.opb_i[WIDTH-1]);
                r_neg <= div_signed && bus.opa_i[WIDTH-1];
                cnt   <= CW'(WIDTH - 1);
                state <= DIV;
              end
            end else if (MUL_LATENCY == 1) begin
              {hi_r, lo_r} <= mul_res;
              done_r       <= 1'b1;
              state        <= DONE;
            end else begin
              cnt   <= CW'(MUL_LATENCY - 2);
              state <= MUL;
            end
          end
          MUL: begin
            if (cnt == '0) begin
              {hi_r, lo_r} <= mul_res;
              done_r       <= 1'b1;
              state        <= DONE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DIV: begin
            rem <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], fits};
            if (cnt == '0) state <= SIGN;
            else           cnt   <= cnt - 1'b1;
          end
          SIGN: begin
            lo_r   <= q_neg ? -quo : quo;
            hi_r   <= r_neg ? -rem : rem;
            done_r <= 1'b1;
            state  <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.stall_o = accept || (state == MUL) || (state == DIV) || (state == SIGN);
  assign bus.done_o  = done_r;
  assign bus.whilo_o = done_r;
  assign bus.hi_o    = hi_r;
  assign bus.lo_o    = lo_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized + directed bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;
  localparam int W   = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ex_muldiv_if #(.WIDTH(W)) bus();

  ex_muldiv #(.WIDTH(W), .MUL_LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] last_res = 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic uns,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] ah, input logic [31:0] al);
    longint sp;
    logic [63:0] up, acc;
    int q, r;
    sp  = longint'($signed(a)) * longint'($signed(b));
    up  = 64'(a) * 64'(b);
    acc = {ah, al};
    case (op)
      3'd1: return sp;
      3'd2: return up;
      3'd5: return acc + sp;
      3'd6: return acc + up;
      3'd7: return uns ? acc - up : acc - sp;
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {32'(r), 32'(q)};
      end
      3'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Called just after a rising edge; that cycle is cycle 0 of the operation.
  task automatic run_op(input string tag, input logic [2:0] op, input logic uns,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ah, input logic [31:0] al);
    logic [63:0] exp;
    int exp_lat, cyc;
    bit seen, stall_ok;
    exp = ref_model(op, uns, a, b, ah, al);
    if (op == 3'd3 || op == 3'd4) exp_lat = (b == 32'd0) ? 1 : W + 2;
    else                          exp_lat = LAT;
    bus.start_i = 1'b1; bus.op_i = op; bus.unsigned_i = uns;
    bus.opa_i = a; bus.opb_i = b; bus.acc_hi_i = ah; bus.acc_lo_i = al;
    cyc = 0; seen = 0; stall_ok = 1;
    while (cyc < 100) begin
      @(negedge clk);
      if (bus.done_o) begin seen = 1; break; end
      if (!bus.stall_o) stall_ok = 0;
      @(posedge clk); #1;
      cyc++;
    end
    bus.start_i = 1'b0;
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_stall"}, 64'(stall_ok), 64'd1);
    if (seen) begin
      chk({tag, "_hilo"}, {bus.hi_o, bus.lo_o}, exp);
      chk({tag, "_whilo"}, 64'(bus.whilo_o), 64'd1);
      chk({tag, "_stall_done"}, 64'(bus.stall_o), 64'd0);
    end
    last_res = exp;
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(bus.done_o), 64'd0);
    chk({tag, "_hold"}, {bus.hi_o, bus.lo_o}, exp);
    @(posedge clk); #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 0; bus.op_i = 0; bus.unsigned_i = 0; bus.opa_i = 0; bus.opb_i = 0;
    bus.acc_hi_i = 0; bus.acc_lo_i = 0; bus.flush_i = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_stall", 64'(bus.stall_o), 64'd0);
    chk("rst_done", 64'(bus.done_o), 64'd0);
    chk("rst_whilo", 64'(bus.whilo_o), 64'd0);
    chk("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cycles(1);

    run_op("mult",   3'd1, 0, 32'hFFFF_FFFE, 32'd3, 0, 0);
    run_op("multu",  3'd2, 0, 32'hFFFF_FFFE, 32'd3, 0, 0);
    run_op("div_m7", 3'd3, 0, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op("div_ovf",3'd3, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("divu_z", 3'd4, 0, 32'd100, 32'd0, 0, 0);
    run_op("madd",   3'd5, 0, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
    run_op("msubu",  3'd7, 1, 32'd1, 32'd1, 32'd0, 32'd0);
    run_op("msub",   3'd7, 0, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd10);
    run_op("div_z",  3'd3, 0, 32'hFFFF_FF00, 32'd0, 0, 0);

    // NOP start is ignored
    bus.start_i = 1; bus.op_i = 3'd0;
    @(negedge clk);
    chk("nop_stall", 64'(bus.stall_o), 64'd0);
    @(posedge clk); #1;
    bus.start_i = 0;
    @(negedge clk);
    chk("nop_done", 64'(bus.done_o), 64'd0);
    @(posedge clk); #1;

    // flush in the start cycle wins over start
    bus.start_i = 1; bus.op_i = 3'd1; bus.flush_i = 1;
    @(negedge clk);
    chk("fl0_stall", 64'(bus.stall_o), 64'd0);
    @(posedge clk); #1;
    bus.start_i = 0; bus.flush_i = 0;
    @(negedge clk);
    chk("fl0_stall2", 64'(bus.stall_o), 64'd0);
    wait_cycles(2);
    chk("fl0_done", 64'(bus.done_o), 64'd0);

    // DIVU flushed at cycle 10, MULT at cycle 12
    bus.start_i = 1; bus.op_i = 3'd4; bus.opa_i = 32'd1000; bus.opb_i = 32'd7;
    wait_cycles(10);
    bus.flush_i = 1;
    @(posedge clk); #1;
    bus.flush_i = 0; bus.start_i = 0;
    @(negedge clk);
    chk("fl_stall", 64'(bus.stall_o), 64'd0);
    chk("fl_done", 64'(bus.done_o), 64'd0);
    chk("fl_hold", {bus.hi_o, bus.lo_o}, last_res);
    @(posedge clk); #1;
    run_op("fl_mult", 3'd1, 0, 32'd1234, 32'hFFFF_FF00, 0, 0);

    // reset at cycle 5 of a DIV clears everything
    bus.start_i = 1; bus.op_i = 3'd3; bus.opa_i = 32'd77; bus.opb_i = 32'd5;
    wait_cycles(5);
    rst = 1; bus.start_i = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    chk("mrst_stall", 64'(bus.stall_o), 64'd0);
    chk("mrst_done", 64'(bus.done_o), 64'd0);
    chk("mrst_whilo", 64'(bus.whilo_o), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    wait_cycles(1);

    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(1, 7));
      run_op($sformatf("rnd%0d", i), op, 1'($urandom_range(0, 1)),
             rnd_opnd(), rnd_opnd(), $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
